// File: rtl/home_inventory_adc_stream_pkg.sv
// rtl/home_inventory_adc_stream_pkg.sv - shared constants, FSM states and header packing for the ADC stream buffer
// Contents: header sync byte and field offsets, clr_i bit positions, FSM state encoding, make_header().
package home_inventory_adc_stream_pkg;

    localparam logic [7:0] HDR_SYNC     = 8'hA5;
    localparam int         HDR_SYNC_LSB = 24;
    localparam int         HDR_SEQ_LSB  = 16;
    localparam int         HDR_DROP_LSB = 8;
    localparam int         HDR_NCH_LSB  = 0;

    localparam int CLR_OVERRUN_BIT   = 0;
    localparam int CLR_FRAME_ERR_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_TS   = 3'd2,
        ST_DATA = 3'd3,
        ST_DROP = 3'd4
    } adc_state_t;

    function automatic logic [31:0] make_header(input logic [7:0] seq,
                                                input logic [7:0] drops,
                                                input logic [3:0] n_ch);
        logic [31:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 8] = HDR_SYNC;
        h[HDR_SEQ_LSB  +: 8] = seq;
        h[HDR_DROP_LSB +: 8] = drops;
        h[HDR_NCH_LSB  +: 4] = n_ch;
        return h;
    endfunction

endpackage

// File: rtl/home_inventory_sync_ram.sv
// rtl/home_inventory_sync_ram.sv - DEPTH x 32 storage, one synchronous write port, combinational read
// Ports: clk_i; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o asynchronous read.
module home_inventory_sync_ram #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/home_inventory_adc_stream.sv
// rtl/home_inventory_adc_stream.sv - frame-atomic ADC sample FIFO with commit/rollback, flags, drop counter and watermark IRQ
// Option macro: HOME_INVENTORY_ADC_TS_EN adds ts_i and a timestamp word after each header.
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; cap_* sample stream in;
//        pop_i/rd_data_o/level_o read side; wm_i/irq_wm_o watermark; overrun_o/frame_err_o
//        sticky flags cleared by clr_i; flush_i empties the FIFO; drop_cnt_o dropped frames.
module home_inventory_adc_stream
    import home_inventory_adc_stream_pkg::*;
#(
    parameter  int N_CH     = 8,
    parameter  int SAMPLE_W = 24,
    parameter  int DEPTH    = 64,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cap_valid_i,
    output logic                cap_ready_o,
    input  logic [SAMPLE_W-1:0] cap_data_i,
    input  logic                cap_last_i,
`ifdef HOME_INVENTORY_ADC_TS_EN
    input  logic [31:0]         ts_i,
`endif
    input  logic                pop_i,
    output logic [31:0]         rd_data_o,
    output logic [AW:0]         level_o,
    input  logic [AW:0]         wm_i,
    output logic                irq_wm_o,
    output logic                overrun_o,
    output logic                frame_err_o,
    input  logic [1:0]          clr_i,
    input  logic                flush_i,
    output logic [15:0]         drop_cnt_o
);

`ifdef HOME_INVENTORY_ADC_TS_EN
    localparam int FRAME_WORDS = N_CH + 2;
`else
    localparam int FRAME_WORDS = N_CH + 1;
`endif

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] FW_W    = (AW+1)'(FRAME_WORDS);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [3:0]  LAST_K  = 4'(N_CH - 1);
    localparam logic [3:0]  NCH_W   = 4'(N_CH);

    adc_state_t  state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [AW:0] rd_q, rd_d, commit_q, commit_d, spec_q, spec_d;
    logic [7:0]  seq_q, seq_d, fdrop_q, fdrop_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        ready_q, ovr_q, ovr_d, err_q, err_d, irq_q, irq_d;

    logic        ovr_set, err_set, drop_inc;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ram_rdata;
    logic [AW:0] level_w, free_w;
    logic        accept, pop_ok;

    logic signed [SAMPLE_W-1:0] smp_s;
    logic        [31:0]         sample_ext;

    assign smp_s      = cap_data_i;
    assign sample_ext = 32'(smp_s);

    assign level_w = commit_q - rd_q;
    assign free_w  = DEPTH_W - level_w;
    assign accept  = cap_valid_i & ready_q;
    assign pop_ok  = pop_i & (level_w != '0);

    home_inventory_sync_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (wb_clk_i),
        .we_i    (we),
        .waddr_i (spec_q[AW-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        rd_d       = rd_q;
        commit_d   = commit_q;
        spec_d     = spec_q;
        seq_d      = seq_q;
        fdrop_d    = fdrop_q;
        drop_cnt_d = drop_cnt_q;
        ovr_set    = 1'b0;
        err_set    = 1'b0;
        drop_inc   = 1'b0;
        we         = 1'b0;
        wdata      = '0;

        if (pop_ok) begin
            rd_d = rd_q + PTR_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                // spec_q equals commit_q here, so committed level is the true occupancy
                if (cap_valid_i) begin
                    if (free_w >= FW_W) begin
                        state_d = ST_HDR;
                    end else begin
                        ovr_set  = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = ST_DROP;
                    end
                end
            end
            ST_HDR: begin
                we     = 1'b1;
                wdata  = make_header(seq_q, fdrop_q, NCH_W);
                spec_d = spec_q + PTR_ONE;
                k_d    = '0;
`ifdef HOME_INVENTORY_ADC_TS_EN
                state_d = ST_TS;
`else
                state_d = ST_DATA;
`endif
            end
`ifdef HOME_INVENTORY_ADC_TS_EN
            ST_TS: begin
                we      = 1'b1;
                wdata   = ts_i;
                spec_d  = spec_q + PTR_ONE;
                state_d = ST_DATA;
            end
`endif
            ST_DATA: begin
                if (accept) begin
                    if (k_q == LAST_K) begin
                        if (cap_last_i) begin
                            we       = 1'b1;
                            wdata    = sample_ext;
                            spec_d   = spec_q + PTR_ONE;
                            commit_d = spec_q + PTR_ONE;
                            seq_d    = seq_q + 8'd1;
                            fdrop_d  = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            // too long: discard the rest of it up to its last marker
                            spec_d   = commit_q;
                            err_set  = 1'b1;
                            drop_inc = 1'b1;
                            state_d  = ST_DROP;
                        end
                    end else if (cap_last_i) begin
                        spec_d   = commit_q;
                        err_set  = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        we     = 1'b1;
                        wdata  = sample_ext;
                        spec_d = spec_q + PTR_ONE;
                        k_d    = k_q + 4'd1;
                    end
                end
            end
            ST_DROP: begin
                if (accept && cap_last_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (drop_inc) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            if (fdrop_d != 8'hFF)       fdrop_d    = fdrop_d + 8'd1;
        end

        // flush discards everything, including a commit or drop decided this cycle
        if (flush_i) begin
            rd_d       = '0;
            commit_d   = '0;
            spec_d     = '0;
            seq_d      = seq_q;
            fdrop_d    = fdrop_q;
            drop_cnt_d = drop_cnt_q;
            ovr_set    = 1'b0;
            err_set    = 1'b0;
            we         = 1'b0;
            if (state_q == ST_IDLE) begin
                state_d = ST_IDLE;
            end else if (state_q != ST_DROP) begin
                // a last marker consumed now already ends the aborted frame
                state_d = (accept && cap_last_i) ? ST_IDLE : ST_DROP;
            end
        end

        ovr_d = (ovr_q & ~clr_i[CLR_OVERRUN_BIT])   | ovr_set;
        err_d = (err_q & ~clr_i[CLR_FRAME_ERR_BIT]) | err_set;
        irq_d = (wm_i != '0) && (level_w >= wm_i);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            rd_q       <= '0;
            commit_q   <= '0;
            spec_q     <= '0;
            seq_q      <= '0;
            fdrop_q    <= '0;
            drop_cnt_q <= '0;
            ready_q    <= 1'b0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rd_q       <= rd_d;
            commit_q   <= commit_d;
            spec_q     <= spec_d;
            seq_q      <= seq_d;
            fdrop_q    <= fdrop_d;
            drop_cnt_q <= drop_cnt_d;
            ready_q    <= (state_d == ST_DATA) || (state_d == ST_DROP);
            ovr_q      <= ovr_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
        end
    end

    assign cap_ready_o = ready_q;
    assign rd_data_o   = (level_w != '0) ? ram_rdata : 32'h0;
    assign level_o     = level_w;
    assign irq_wm_o    = irq_q;
    assign overrun_o   = ovr_q;
    assign frame_err_o = err_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_home_inventory_adc_stream.sv
// tb/tb_home_inventory_adc_stream.sv - self-checking bench for home_inventory_adc_stream (N_CH=8, SAMPLE_W=24, DEPTH=16)
module tb_home_inventory_adc_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_valid_i = 1'b0;
    logic        cap_ready_o;
    logic [23:0] cap_data_i = '0;
    logic        cap_last_i = 1'b0;
`ifdef HOME_INVENTORY_ADC_TS_EN
    logic [31:0] ts_i = '0;
`endif
    logic        pop_i = 1'b0;
    logic [31:0] rd_data_o;
    logic [4:0]  level_o;
    logic [4:0]  wm_i = '0;
    logic        irq_wm_o;
    logic        overrun_o;
    logic        frame_err_o;
    logic [1:0]  clr_i = '0;
    logic        flush_i = 1'b0;
    logic [15:0] drop_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  m_seq   = '0;
    logic [7:0]  m_fdrop = '0;

    typedef struct {
        int          nsamp;
        int          last_at;
        logic [23:0] base;
        int          pops;
        logic [1:0]  clr;
        int          exp_level;
        logic        exp_ovr;
        logic        exp_err;
        int          exp_drop;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    home_inventory_adc_stream #(.N_CH(8), .SAMPLE_W(24), .DEPTH(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cap_valid_i (cap_valid_i),
        .cap_ready_o (cap_ready_o),
        .cap_data_i  (cap_data_i),
        .cap_last_i  (cap_last_i),
`ifdef HOME_INVENTORY_ADC_TS_EN
        .ts_i        (ts_i),
`endif
        .pop_i       (pop_i),
        .rd_data_o   (rd_data_o),
        .level_o     (level_o),
        .wm_i        (wm_i),
        .irq_wm_o    (irq_wm_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o),
        .clr_i       (clr_i),
        .flush_i     (flush_i),
        .drop_cnt_o  (drop_cnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send_sample(input logic [23:0] d, input logic last, input bit pop_now);
        int t;
        logic [31:0] e;
        t = 0;
        cap_valid_i = 1'b1;
        cap_data_i  = d;
        cap_last_i  = last;
        while (cap_ready_o !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'(cap_ready_o), 32'h1);
        if (pop_now) begin
            if (exp_q.size() == 0) begin
                chk("pop_at_commit_empty", 32'(exp_q.size()), 32'h1);
            end else begin
                e = exp_q.pop_front();
                chk("pop_at_commit_data", rd_data_o, e);
                pop_i = 1'b1;
            end
        end
        @(negedge clk);
        cap_valid_i = 1'b0;
        cap_last_i  = 1'b0;
        pop_i       = 1'b0;
    endtask

    task automatic send_frame(input int nsamp, input int last_at, input logic [23:0] base, input bit pop_last);
        bit          fits;
        logic [23:0] s;
        fits = (16 - exp_q.size()) >= 9;
        for (int i = 0; i < nsamp; i++) begin
            send_sample(base + 24'(i), (i == last_at), pop_last && (i == nsamp - 1));
        end
        if (fits && nsamp == 8 && last_at == 7) begin
            exp_q.push_back({8'hA5, m_seq, m_fdrop, 8'h08});
            for (int i = 0; i < 8; i++) begin
                s = base + 24'(i);
                exp_q.push_back({{8{s[23]}}, s});
            end
            m_seq   = m_seq + 8'd1;
            m_fdrop = '0;
        end else if (m_fdrop != 8'hFF) begin
            m_fdrop = m_fdrop + 8'd1;
        end
    endtask

    task automatic pop_check(input string nm);
        logic [31:0] e;
        chk({nm, "_level"}, 32'(level_o), 32'(exp_q.size()));
        if (exp_q.size() == 0) begin
            chk({nm, "_empty"}, rd_data_o, 32'h0);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_data"}, rd_data_o, e);
            pop_i = 1'b1;
            @(negedge clk);
            pop_i = 1'b0;
        end
    endtask

    initial begin
        tbl[0] = '{8, 7, 24'h000001, 9, 2'd0, 9, 1'b0, 1'b0, 0};
        tbl[1] = '{8, 7, 24'h800000, 0, 2'd0, 9, 1'b0, 1'b0, 0};
        tbl[2] = '{8, 7, 24'h000010, 9, 2'd1, 9, 1'b1, 1'b0, 1};
        tbl[3] = '{8, 7, 24'h000020, 9, 2'd0, 9, 1'b0, 1'b0, 1};
        tbl[4] = '{5, 4, 24'h000030, 0, 2'd0, 0, 1'b0, 1'b1, 2};
        tbl[5] = '{9, 8, 24'h000040, 0, 2'd2, 0, 1'b0, 1'b1, 3};
        tbl[6] = '{8, 7, 24'h000050, 9, 2'd0, 9, 1'b0, 1'b0, 3};

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready",   32'(cap_ready_o), 32'h0);
        chk("rst_rd_data", rd_data_o,        32'h0);
        chk("rst_level",   32'(level_o),     32'h0);
        chk("rst_irq",     32'(irq_wm_o),    32'h0);
        chk("rst_ovr",     32'(overrun_o),   32'h0);
        chk("rst_err",     32'(frame_err_o), 32'h0);
        chk("rst_drop",    32'(drop_cnt_o),  32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            send_frame(tbl[v].nsamp, tbl[v].last_at, tbl[v].base, 1'b0);
            chk($sformatf("v%0d_level", v), 32'(level_o),     32'(tbl[v].exp_level));
            chk($sformatf("v%0d_ovr", v),   32'(overrun_o),   32'(tbl[v].exp_ovr));
            chk($sformatf("v%0d_err", v),   32'(frame_err_o), 32'(tbl[v].exp_err));
            chk($sformatf("v%0d_drop", v),  32'(drop_cnt_o),  32'(tbl[v].exp_drop));
            chk($sformatf("v%0d_irq", v),   32'(irq_wm_o),    32'h0);
            for (int p = 0; p < tbl[v].pops; p++) pop_check($sformatf("v%0d_pop%0d", v, p));
            if (tbl[v].clr != 2'd0) begin
                clr_i = tbl[v].clr;
                @(negedge clk);
                clr_i = '0;
            end
        end

        // pop and commit on the same edge at level 3
        send_frame(8, 7, 24'h000060, 1'b0);
        for (int p = 0; p < 6; p++) pop_check($sformatf("pc_pre%0d", p));
        chk("pc_level3", 32'(level_o), 32'd3);
        send_frame(8, 7, 24'h000070, 1'b1);
        chk("pc_level11", 32'(level_o), 32'd11);
        for (int p = 0; p < 11; p++) pop_check($sformatf("pc_drain%0d", p));

        // flush in the middle of a frame
        send_frame(8, 7, 24'h000080, 1'b0);
        pop_check("fl_pre0");
        pop_check("fl_pre1");
        for (int i = 0; i < 3; i++) send_sample(24'h000090 + 24'(i), 1'b0, 1'b0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        exp_q.delete();
        chk("fl_level",   32'(level_o),    32'h0);
        chk("fl_rd_data", rd_data_o,       32'h0);
        chk("fl_drop",    32'(drop_cnt_o), 32'd3);
        for (int i = 3; i < 8; i++) send_sample(24'h000090 + 24'(i), (i == 7), 1'b0);
        chk("fl_level_after", 32'(level_o),     32'h0);
        chk("fl_drop_after",  32'(drop_cnt_o),  32'd3);
        chk("fl_err_after",   32'(frame_err_o), 32'h0);
        chk("fl_ovr_after",   32'(overrun_o),   32'h0);
        send_frame(8, 7, 24'h0000A0, 1'b0);
        for (int p = 0; p < 9; p++) pop_check($sformatf("fl_post%0d", p));

        // watermark lags level by one cycle
        wm_i = 5'd9;
        @(negedge clk);
        send_frame(8, 7, 24'h0000B0, 1'b0);
        chk("wm_level9",  32'(level_o),  32'd9);
        chk("wm_irq_lag", 32'(irq_wm_o), 32'h0);
        @(negedge clk);
        chk("wm_irq_set", 32'(irq_wm_o), 32'h1);
        pop_check("wm_pop0");
        chk("wm_irq_hold", 32'(irq_wm_o), 32'h1);
        @(negedge clk);
        chk("wm_irq_clear", 32'(irq_wm_o), 32'h0);
        for (int p = 1; p < 9; p++) pop_check($sformatf("wm_pop%0d", p));
        wm_i = '0;

        // many frames: pointers wrap several times, headers carry consecutive seq
        for (int f = 0; f < 10; f++) begin
            send_frame(8, 7, 24'h100000 + 24'(f * 16), 1'b0);
            for (int p = 0; p < 9; p++) pop_check($sformatf("wr_f%0d_p%0d", f, p));
        end

        // reset mid-frame clears all outputs at once
        wm_i = 5'd4;
        send_frame(8, 7, 24'h0000C0, 1'b0);
        pop_check("rs_pre0");
        pop_check("rs_pre1");
        chk("rs_irq_before", 32'(irq_wm_o), 32'h1);
        for (int i = 0; i < 3; i++) send_sample(24'h0000D0 + 24'(i), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rs_ready",   32'(cap_ready_o), 32'h0);
        chk("rs_rd_data", rd_data_o,        32'h0);
        chk("rs_level",   32'(level_o),     32'h0);
        chk("rs_irq",     32'(irq_wm_o),    32'h0);
        chk("rs_ovr",     32'(overrun_o),   32'h0);
        chk("rs_err",     32'(frame_err_o), 32'h0);
        chk("rs_drop",    32'(drop_cnt_o),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
